simon_iter_engine: RTL and testbench

Iterative, parameterised Simon-family block cipher engine: one Feistel round per clock, using a preloaded round-key register file, in encrypt or decrypt mode selected per block. It is the sequential successor of the single combinational 2×32-bit round and is generalised in word width, round count and rotation constants. It sits between a valid/ready block source and sink, and round keys are written by a host-side key-load port.

---
 rtl/simon_iter_engine.sv | 144 ++++++++++++++
 tb/tb_simon_iter_engine.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_iter_engine.sv
// Iterative Simon-family Feistel engine: one round per clock from a
// preloaded round-key file, encrypt or decrypt chosen per block.
module simon_iter_engine #(
    parameter int WORD   = 32,
    parameter int ROUNDS = 44,
    parameter int ROT_A  = 1,
    parameter int ROT_B  = 8,
    parameter int ROT_C  = 2,
    localparam int KW    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_we,
    input  logic [KW-1:0]     key_addr,
    input  logic [WORD-1:0]   key_data,
    output logic              key_ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [2*WORD-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*WORD-1:0] out_data
);

    localparam int unsigned RA = ROT_A % WORD;
    localparam int unsigned RB = ROT_B % WORD;
    localparam int unsigned RC = ROT_C % WORD;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            st;
    logic              mode;
    logic [KW-1:0]     rc;
    logic [2*WORD-1:0] blk;
    logic [WORD-1:0]   keys [ROUNDS];
    logic [WORD-1:0]   rk;
    logic [KW-1:0]     kidx;
    logic [2*WORD-1:0] nxt;
    logic              last;

    function automatic logic [WORD-1:0] rotl(
        input logic [WORD-1:0] x,
        input int unsigned     n
    );
        return (x << n) | (x >> (WORD - n));
    endfunction

    function automatic logic [WORD-1:0] rf(
        input logic [WORD-1:0] x
    );
        return (rotl(x, RA) & rotl(x, RB)) ^ rotl(x, RC);
    endfunction

    function automatic logic [2*WORD-1:0] swap(
        input logic [2*WORD-1:0] x
    );
        return {x[WORD-1:0], x[2*WORD-1:WORD]};
    endfunction

    // Decrypt walks the key file backwards over a word-swapped state
    assign kidx = mode ? (KW'(ROUNDS - 1) - rc) : rc;
    assign last = (rc == KW'(ROUNDS - 1));

    always_comb begin
        rk = '0;
        for (int i = 0; i < ROUNDS; i++) begin
            if (kidx == KW'(i)) begin
                rk = keys[i];
            end
        end
    end

    assign nxt = {blk[WORD-1:0] ^ rf(blk[2*WORD-1:WORD]) ^ rk,
                  blk[2*WORD-1:WORD]};

    // Addresses at or beyond ROUNDS match no entry and are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROUNDS; i++) begin
                keys[i] <= '0;
            end
        end else if (key_we && key_ready) begin
            for (int i = 0; i < ROUNDS; i++) begin
                if (key_addr == KW'(i)) begin
                    keys[i] <= key_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            mode      <= 1'b0;
            rc        <= '0;
            blk       <= '0;
            in_ready  <= 1'b1;
            key_ready <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            unique case (st)
                IDLE: begin
                    if (in_valid) begin
                        mode      <= in_mode;
                        blk       <= in_mode ? swap(in_data) : in_data;
                        rc        <= '0;
                        in_ready  <= 1'b0;
                        key_ready <= 1'b0;
                        st        <= RUN;
                    end
                end
                RUN: begin
                    blk <= nxt;
                    if (last) begin
                        rc        <= '0;
                        out_valid <= 1'b1;
                        out_data  <= mode ? swap(nxt) : nxt;
                        st        <= DONE;
                    end else begin
                        rc <= rc + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        key_ready <= 1'b1;
                        st        <= IDLE;
                    end
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_iter_engine.sv
// Bench for simon_iter_engine: a one-round instance and a default
// Simon64/128 instance, checked against a behavioural cipher model.
module tb_simon_iter_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_key_we, a_key_ready, a_in_valid, a_in_ready;
    logic        a_in_mode, a_out_valid, a_out_ready;
    logic [0:0]  a_key_addr;
    logic [31:0] a_key_data;
    logic [63:0] a_in_data, a_out_data;

    logic        b_key_we, b_key_ready, b_in_valid, b_in_ready;
    logic        b_in_mode, b_out_valid, b_out_ready;
    logic [5:0]  b_key_addr;
    logic [31:0] b_key_data;
    logic [63:0] b_in_data, b_out_data;

    simon_iter_engine #(.WORD(32), .ROUNDS(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .key_we(a_key_we), .key_addr(a_key_addr),
        .key_data(a_key_data), .key_ready(a_key_ready),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_mode(a_in_mode), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data)
    );

    simon_iter_engine u_b (
        .clk(clk), .rst_n(rst_n),
        .key_we(b_key_we), .key_addr(b_key_addr),
        .key_data(b_key_data), .key_ready(b_key_ready),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_mode(b_in_mode), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] ka [44];
    logic [31:0] kb [44];

    typedef struct {
        logic [31:0] key;
        bit          mode;
        logic [63:0] din;
        logic [63:0] dout;
    } vec_t;
    vec_t va [3];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    function automatic logic [31:0] ff(input logic [31:0] x);
        return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
    endfunction

    function automatic logic [63:0] model(input logic [63:0] d, input bit dec,
                                          input logic [31:0] ks [44],
                                          input int nr);
        logic [31:0] x, y, t;
        x = d[63:32];
        y = d[31:0];
        if (!dec) begin
            for (int i = 0; i < nr; i++) begin
                t = x;
                x = y ^ ff(x) ^ ks[i];
                y = t;
            end
        end else begin
            for (int i = nr - 1; i >= 0; i--) begin
                t = y;
                y = x ^ ff(y) ^ ks[i];
                x = t;
            end
        end
        return {x, y};
    endfunction

    task automatic expand_keys();
        logic [63:0] z3;
        logic [31:0] tmp;
        z3 = 64'hfc2ce51207a635db;
        kb[0] = 32'h03020100;
        kb[1] = 32'h0b0a0908;
        kb[2] = 32'h13121110;
        kb[3] = 32'h1b1a1918;
        for (int i = 4; i < 44; i++) begin
            tmp = rol(kb[i-1], 29) ^ kb[i-3];
            tmp = tmp ^ rol(tmp, 31);
            kb[i] = ~kb[i-4] ^ tmp ^ {31'b0, z3[(i-4)%62]} ^ 32'h3;
        end
    endtask

    task automatic a_key(input logic [31:0] d);
        a_key_we = 1'b1; a_key_addr = 1'b0; a_key_data = d;
        @(posedge clk); #1;
        a_key_we = 1'b0;
    endtask

    task automatic b_key(input logic [5:0] ad, input logic [31:0] d);
        b_key_we = 1'b1; b_key_addr = ad; b_key_data = d;
        @(posedge clk); #1;
        b_key_we = 1'b0;
    endtask

    task automatic a_block(input bit m, input logic [63:0] d,
                           output logic [63:0] res, output int lat);
        chk("a_in_ready_pre", {63'b0, a_in_ready}, 64'd1);
        a_in_mode = m; a_in_data = d; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        res = a_out_data;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
    endtask

    task automatic b_finish(output logic [63:0] res, output int lat);
        lat = 1;
        while (!b_out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        res = b_out_data;
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        chk("b_in_ready_after", {63'b0, b_in_ready}, 64'd1);
    endtask

    task automatic b_accept(input bit m, input logic [63:0] d);
        chk("b_in_ready_pre", {63'b0, b_in_ready}, 64'd1);
        b_in_mode = m; b_in_data = d; b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic b_block(input bit m, input logic [63:0] d,
                           output logic [63:0] res, output int lat);
        b_accept(m, d);
        b_finish(res, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] res, d1, d2, e1;
        int lat;
        bit m;

        a_key_we = 0; a_key_addr = 0; a_key_data = 0;
        a_in_valid = 0; a_in_mode = 0; a_in_data = 0; a_out_ready = 0;
        b_key_we = 0; b_key_addr = 0; b_key_data = 0;
        b_in_valid = 0; b_in_mode = 0; b_in_data = 0; b_out_ready = 0;
        for (int i = 0; i < 44; i++) begin
            ka[i] = '0; kb[i] = '0;
        end

        #12;
        chk("rst_a_in_ready", {63'b0, a_in_ready}, 64'd1);
        chk("rst_a_key_ready", {63'b0, a_key_ready}, 64'd1);
        chk("rst_a_out_valid", {63'b0, a_out_valid}, 64'd0);
        chk("rst_a_out_data", a_out_data, 64'd0);
        chk("rst_b_in_ready", {63'b0, b_in_ready}, 64'd1);
        chk("rst_b_key_ready", {63'b0, b_key_ready}, 64'd1);
        chk("rst_b_out_valid", {63'b0, b_out_valid}, 64'd0);
        chk("rst_b_out_data", b_out_data, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        va[0] = '{32'hFEDCBA98, 1'b0, 64'h0123456789ABCDEF, 64'h71BE60EB01234567};
        va[1] = '{32'hFEDCBA98, 1'b1, 64'h71BE60EB01234567, 64'h0123456789ABCDEF};
        va[2] = '{32'h8899AABB, 1'b0, 64'h0011223344556677, 64'hCCAA440000112233};
        for (int i = 0; i < 3; i++) begin
            a_key(va[i].key);
            ka[0] = va[i].key;
            a_block(va[i].mode, va[i].din, res, lat);
            chk("a_vec", res, va[i].dout);
            chk("a_vec_model", res, model(va[i].din, va[i].mode, ka, 1));
            chk("a_latency", 64'(lat), 64'd2);
        end

        expand_keys();
        for (int i = 0; i < 44; i++) b_key(6'(i), kb[i]);
        b_block(1'b0, 64'h656B696C20646E75, res, lat);
        chk("b_enc_vec", res, 64'h44C8FC20B9DFA07A);
        chk("b_enc_model", res, model(64'h656B696C20646E75, 1'b0, kb, 44));
        chk("b_latency", 64'(lat), 64'd45);
        b_block(1'b1, 64'h44C8FC20B9DFA07A, res, lat);
        chk("b_dec_vec", res, 64'h656B696C20646E75);

        for (int i = 0; i < 6; i++) begin
            d1 = {$urandom, $urandom};
            m = 1'($urandom_range(0, 1));
            b_block(m, d1, res, lat);
            chk("b_rand", res, model(d1, m, kb, 44));
        end

        d1 = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        e1 = model(d1, 1'b0, kb, 44);
        b_accept(1'b0, d1);
        lat = 1;
        while (!b_out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk("bp_first", b_out_data, e1);
        b_in_valid = 1'b1; b_in_data = d2; b_in_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_data", b_out_data, e1);
            chk("bp_hold_valid", {63'b0, b_out_valid}, 64'd1);
            chk("bp_in_ready", {63'b0, b_in_ready}, 64'd0);
        end
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        chk("bp_out_drop", {63'b0, b_out_valid}, 64'd0);
        chk("bp_ready_back", {63'b0, b_in_ready}, 64'd1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        chk("bp_second_taken", {63'b0, b_in_ready}, 64'd0);
        b_finish(res, lat);
        chk("bp_second", res, model(d2, 1'b1, kb, 44));
        chk("bp_second_lat", 64'(lat), 64'd45);

        d1 = {$urandom, $urandom};
        b_accept(1'b0, d1);
        for (int i = 0; i < 8; i++) begin
            chk("busy_key_ready", {63'b0, b_key_ready}, 64'd0);
            b_key_we = 1'b1;
            b_key_addr = 6'($urandom_range(0, 43));
            b_key_data = $urandom;
            @(posedge clk); #1;
        end
        b_key_we = 1'b0;
        b_finish(res, lat);
        chk("busy_write_enc", res, model(d1, 1'b0, kb, 44));
        b_key(6'd44, $urandom);
        b_key(6'd63, $urandom);
        d1 = {$urandom, $urandom};
        b_block(1'b1, d1, res, lat);
        chk("oor_write_dec", res, model(d1, 1'b1, kb, 44));
        d1 = {$urandom, $urandom};
        b_block(1'b0, d1, res, lat);
        chk("oor_write_enc", res, model(d1, 1'b0, kb, 44));

        d1 = {$urandom, $urandom};
        kb[0] = $urandom;
        b_key_we = 1'b1; b_key_addr = 6'd0; b_key_data = kb[0];
        b_in_valid = 1'b1; b_in_mode = 1'b0; b_in_data = d1;
        @(posedge clk); #1;
        b_key_we = 1'b0; b_in_valid = 1'b0;
        b_finish(res, lat);
        chk("same_cycle_key", res, model(d1, 1'b0, kb, 44));

        d1 = {$urandom, $urandom};
        b_accept(1'b0, d1);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {63'b0, b_out_valid}, 64'd0);
        chk("mid_rst_out_data", b_out_data, 64'd0);
        chk("mid_rst_a_out_data", a_out_data, 64'd0);
        chk("mid_rst_in_ready", {63'b0, b_in_ready}, 64'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {63'b0, b_in_ready}, 64'd1);
        chk("post_rst_key_ready", {63'b0, b_key_ready}, 64'd1);
        chk("post_rst_out_valid", {63'b0, b_out_valid}, 64'd0);
        for (int i = 0; i < 44; i++) kb[i] = '0;
        d1 = {$urandom, $urandom};
        b_block(1'b0, d1, res, lat);
        chk("zero_key_enc", res, model(d1, 1'b0, kb, 44));
        for (int i = 0; i < 44; i++) ka[i] = '0;
        d1 = {$urandom, $urandom};
        a_block(1'b0, d1, res, lat);
        chk("a_zero_key_enc", res, model(d1, 1'b0, ka, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
